// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, per-packet sharing of one UART byte transmitter
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int GAP_CLKS  = 868
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ-1:0]   i_last,
  input  logic [8*N_REQ-1:0] i_data,
  output logic [N_REQ-1:0]   o_ack,
  output logic [N_REQ-1:0]   o_grant,
  input  logic               i_tx_busy,
  output logic               o_tx_start,
  output logic [7:0]         o8_tx_data,
  output logic [7:0]         o8_state,
  output logic [7:0]         o8_burst_cnt
);
  localparam int IW = $clog2(N_REQ);
  localparam int GW = GAP_CLKS > 1 ? $clog2(GAP_CLKS) : 1;
  localparam logic [2:0] IDLE = 3'd0, ARB = 3'd1, SEND = 3'd2, WAIT_ACCEPT = 3'd3, WAIT_DONE = 3'd4, GAP = 3'd5;
  localparam logic [7:0] MB = 8'(MAX_BURST);
  logic [2:0] state_q, state_d, rel_state;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, win;
  logic found;
  logic [N_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic start_q, start_d, end_q, end_d;
  logic [7:0] data_q, data_d, burst_q, burst_d;
  logic [GW-1:0] gap_q, gap_d;
  assign rel_state = GAP_CLKS != 0 ? GAP : IDLE;
  // First requester after the pointer, wrapping; the pointer holds the last packet owner.
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++)
      if (!found && i_req[(int'(ptr_q) + i) % N_REQ]) begin
        found = 1'b1;
        win = IW'((int'(ptr_q) + i) % N_REQ);
      end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    burst_d = burst_q;
    end_d = end_q;
    gap_d = gap_q;
    data_d = data_q;
    ack_d = '0;
    start_d = 1'b0;
    case (state_q)
      IDLE: state_d = |i_req ? ARB : IDLE;
      ARB: begin
        state_d = found ? SEND : IDLE;
        if (found) begin
          owner_d = win;
          grant_d = N_REQ'(1) << win;
          burst_d = '0;
        end
      end
      SEND:
        if (!i_req[owner_q]) begin
          grant_d = '0;
          gap_d = '0;
          state_d = burst_q != 8'd0 ? rel_state : IDLE;
        end else if (!i_tx_busy) begin
          data_d = i_data[8*owner_q +: 8];
          start_d = 1'b1;
          ack_d[owner_q] = 1'b1;
          burst_d = burst_q == MB ? burst_q : burst_q + 8'd1;
          end_d = i_last[owner_q] || burst_q == MB - 8'd1;
          state_d = WAIT_ACCEPT;
        end
      WAIT_ACCEPT: state_d = i_tx_busy ? WAIT_DONE : WAIT_ACCEPT;
      WAIT_DONE:
        if (!i_tx_busy) begin
          state_d = end_q ? rel_state : SEND;
          if (end_q) begin
            grant_d = '0;
            ptr_d = owner_q;
            gap_d = '0;
          end
        end
      GAP: begin
        gap_d = gap_q + GW'(1);
        state_d = gap_q == GW'(GAP_CLKS - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= IW'(N_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      ack_q <= '0;
      start_q <= 1'b0;
      end_q <= 1'b0;
      data_q <= '0;
      burst_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      start_q <= start_d;
      end_q <= end_d;
      data_q <= data_d;
      burst_q <= burst_d;
      gap_q <= gap_d;
    end
  assign o_ack = ack_q;
  assign o_grant = grant_q;
  assign o_tx_start = start_q;
  assign o8_tx_data = data_q;
  assign o8_state = {5'd0, state_q};
  assign o8_burst_cnt = burst_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: requester queues + engine model, packet-level round-robin reference
module tb_uart_tx_arbiter;
  localparam int N = 4, MB = 16, G = 8;
  logic sclk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] i_req, i_last, o_ack, o_grant;
  logic [8*N-1:0] i_data;
  logic i_tx_busy, o_tx_start;
  logic [7:0] o8_tx_data, o8_state, o8_burst_cnt;
  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .GAP_CLKS(G)) dut (
    .sclk(sclk), .rst_n(rst_n), .i_req(i_req), .i_last(i_last), .i_data(i_data),
    .o_ack(o_ack), .o_grant(o_grant), .i_tx_busy(i_tx_busy), .o_tx_start(o_tx_start),
    .o8_tx_data(o8_tx_data), .o8_state(o8_state), .o8_burst_cnt(o8_burst_cnt)
  );
  always #5 sclk = ~sclk;
  int total = 0, bad = 0;
  logic [8:0] rq [N][$];
  int mown = -1, mcnt = 0, mptr = N - 1, step_no = 0, fall_step = 0, starts = 0;
  int e_dly = 0, e_len = 0, force_b = 0;
  bit mdone = 0, have_fall = 0, pend = 0, eng = 0;
  logic [N-1:0] prev_g = '0;
  int gord[$], gbytes[$];
  function automatic bit any_pending();
    for (int k = 0; k < N; k++) if (rq[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_req[k] = rq[k].size() > 0;
      i_data[8*k +: 8] = rq[k].size() > 0 ? rq[k][0][7:0] : 8'h00;
      i_last[k] = rq[k].size() > 0 ? rq[k][0][8] : 1'b0;
    end
  endtask
  task automatic push_pkt(int k, int len, bit with_last);
    for (int i = 0; i < len; i++) rq[k].push_back({with_last && i == len - 1, 8'($urandom)});
  endtask
  task automatic step();
    int w, run;
    logic [8:0] h;
    @(negedge sclk);
    step_no++;
    if (prev_g == '0 && o_grant != '0) begin
      w = -1;
      for (int i = 1; i <= N; i++) if (w < 0 && rq[(mptr + i) % N].size() > 0) w = (mptr + i) % N;
      total++;
      if (w < 0 || o_grant !== (N)'(1) << w) begin
        bad++;
        $display("FAIL grant_rr: grant=%b want requester %0d", o_grant, w);
      end
      if (have_fall) begin
        run = step_no - fall_step;
        total++;
        if (pend ? run != G + 2 : run < G + 2) begin
          bad++;
          $display("FAIL gap_len: idle=%0d want %0d", run, G + 2);
        end
      end
      mown = w; mcnt = 0; mdone = 0;
      gord.push_back(w);
    end
    if (o_tx_start) begin
      starts++;
      h = 9'h1ff;
      if (mown >= 0) if (rq[mown].size() > 0) h = rq[mown][0];
      total++;
      if (mown < 0 || mdone || h == 9'h1ff || o_ack !== (N)'(1) << mown || o8_tx_data !== h[7:0]) begin
        bad++;
        $display("FAIL start: ack=%b data=%h want owner %0d data %h done=%0d", o_ack, o8_tx_data, mown, h[7:0], mdone);
      end
      if (h != 9'h1ff) begin
        void'(rq[mown].pop_front());
        mcnt++;
        if (h[8] || mcnt == MB) begin mdone = 1; mptr = mown; end
      end
      total++;
      if (o8_burst_cnt !== 8'(mcnt)) begin
        bad++;
        $display("FAIL burst_cnt: got %0d want %0d", o8_burst_cnt, mcnt);
      end
    end else if (o_ack != '0) begin
      total++; bad++;
      $display("FAIL ack_no_start: ack=%b want 0", o_ack);
    end
    if (prev_g != '0 && o_grant == '0) begin
      total++;
      if (mown < 0 || !(mdone || rq[mown].size() == 0) || o8_burst_cnt !== 8'(mcnt)) begin
        bad++;
        $display("FAIL release: owner=%0d sent=%0d burst_cnt=%0d done=%0d", mown, mcnt, o8_burst_cnt, mdone);
      end
      gbytes.push_back(mcnt);
      mown = -1; have_fall = 1; fall_step = step_no; pend = any_pending();
    end
    prev_g = o_grant;
    if (o_tx_start) begin e_dly = $urandom_range(0, 2); e_len = $urandom_range(1, 8); end
    if (e_dly > 0) begin e_dly--; eng = 0; end
    else if (e_len > 0) begin eng = 1; e_len--; end
    else eng = 0;
    if (force_b > 0) force_b--;
    i_tx_busy = eng || force_b > 0;
    drive();
  endtask
  task automatic run_idle(int limit);
    int n = 0;
    while ((any_pending() || mown >= 0 || o8_state != 8'd0 || e_len > 0 || e_dly > 0 || force_b > 0) && n < limit) begin
      step(); n++;
    end
    total++;
    if (n >= limit) begin bad++; $display("FAIL timeout: %0d steps without reaching idle", n); end
  endtask
  task automatic test_reset();
    i_tx_busy = 1'b0; drive();
    repeat (3) @(negedge sclk);
    total++;
    if ({o_grant, o_ack, o_tx_start, o8_tx_data} !== '0) begin
      bad++; $display("FAIL reset_out: grant=%b ack=%b start=%b data=%h want 0", o_grant, o_ack, o_tx_start, o8_tx_data);
    end
    total++;
    if (o8_state !== 8'd0 || o8_burst_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_dbg: state=%0d burst=%0d want 0", o8_state, o8_burst_cnt);
    end
    rst_n = 1'b1;
    repeat (2) step();
  endtask
  task automatic test_contention();
    int n = 0;
    int want[4] = '{0, 1, 3, 0};
    gord.delete();
    push_pkt(0, 1, 1); push_pkt(1, 1, 1); push_pkt(3, 1, 1);
    drive();
    while (gord.size() < 2 && n < 300) begin step(); n++; end
    push_pkt(0, 1, 1); drive();
    run_idle(2000);
    total++;
    if (gord.size() != 4) begin bad++; $display("FAIL contention_n: grants=%0d want 4", gord.size()); end
    for (int i = 0; i < 4 && i < gord.size(); i++) begin
      total++;
      if (gord[i] != want[i]) begin bad++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, gord[i], want[i]); end
    end
  endtask
  task automatic test_single();
    int n = 0, s0 = starts;
    gord.delete();
    rq[0].push_back({1'b0, 8'h41}); rq[0].push_back({1'b0, 8'h42}); rq[0].push_back({1'b1, 8'h43});
    drive();
    while (starts == s0 && n < 20) begin step(); n++; end
    total++;
    if (n != 3) begin bad++; $display("FAIL latency: got %0d cycles want 3", n); end
    run_idle(2000);
    total++;
    if (starts - s0 != 3 || gord.size() != 1) begin
      bad++; $display("FAIL single: starts=%0d grants=%0d want 3 and 1", starts - s0, gord.size());
    end
  endtask
  task automatic test_burst();
    int n = 0;
    int want[3] = '{16, 1, 4};
    gord.delete(); gbytes.delete();
    push_pkt(2, 20, 1); drive();
    while (gord.size() == 0 && n < 20) begin step(); n++; end
    push_pkt(1, 1, 1); drive();
    run_idle(5000);
    total++;
    if (gbytes.size() != 3 || gord.size() != 3) begin
      bad++; $display("FAIL burst_n: releases=%0d grants=%0d want 3", gbytes.size(), gord.size());
    end
    for (int i = 0; i < 3 && i < gbytes.size() && i < gord.size(); i++) begin
      total++;
      if (gbytes[i] != want[i] || gord[i] != (i == 1 ? 1 : 2)) begin
        bad++; $display("FAIL burst_grant[%0d]: owner=%0d bytes=%0d want %0d/%0d", i, gord[i], gbytes[i], i == 1 ? 1 : 2, want[i]);
      end
    end
  endtask
  task automatic test_withdraw();
    gord.delete(); gbytes.delete();
    push_pkt(1, 2, 0); drive();
    run_idle(2000);
    total++;
    if (gord.size() != 1 || gbytes.size() != 1) begin
      bad++; $display("FAIL withdraw: grants=%0d releases=%0d want 1", gord.size(), gbytes.size());
    end else if (gord[0] != 1 || gbytes[0] != 2) begin
      bad++; $display("FAIL withdraw: owner=%0d bytes=%0d want 1/2", gord[0], gbytes[0]);
    end
  endtask
  task automatic test_busy_hold();
    int s0 = starts;
    gord.delete();
    push_pkt(3, 1, 1);
    force_b = 50; i_tx_busy = 1'b1; drive();
    while (force_b > 0) step();
    total++;
    if (starts != s0 || o8_state !== 8'd2) begin
      bad++; $display("FAIL busy_hold: starts=%0d state=%0d want 0 starts in SEND", starts - s0, o8_state);
    end
    step();
    total++;
    if (starts != s0 + 1) begin bad++; $display("FAIL busy_release: starts=%0d want 1", starts - s0); end
    run_idle(2000);
    total++;
    if (starts != s0 + 1) begin bad++; $display("FAIL busy_once: starts=%0d want 1", starts - s0); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    push_pkt(0, 2, 1); drive();
    while (o8_state != 8'd4 && n < 100) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_grant, o_ack, o_tx_start, o8_tx_data, o8_state, o8_burst_cnt} !== '0) begin
      bad++; $display("FAIL reset_mid: grant=%b ack=%b start=%b data=%h state=%0d burst=%0d want 0",
                      o_grant, o_ack, o_tx_start, o8_tx_data, o8_state, o8_burst_cnt);
    end
    for (int k = 0; k < N; k++) rq[k].delete();
    mown = -1; mptr = N - 1; have_fall = 0; prev_g = '0;
    e_dly = 0; e_len = 0; force_b = 0; i_tx_busy = 1'b0;
    gord.delete();
    for (int k = 0; k < N; k++) push_pkt(k, 1, 1);
    drive();
    repeat (2) step();
    rst_n = 1'b1;
    run_idle(3000);
    total++;
    if (gord.size() != 4) begin bad++; $display("FAIL reset_order_n: grants=%0d want 4", gord.size()); end
    else if (gord[0] != 0 || gord[1] != 1 || gord[2] != 2 || gord[3] != 3) begin
      bad++; $display("FAIL reset_order: %0d %0d %0d %0d want 0 1 2 3", gord[0], gord[1], gord[2], gord[3]);
    end
  endtask
  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++)
        repeat ($urandom_range(0, 2)) push_pkt(k, $urandom_range(1, 20), $urandom_range(0, 4) != 0);
      drive();
      repeat (400) begin
        step();
        if ($urandom_range(0, 49) == 0) begin
          push_pkt($urandom_range(0, N - 1), $urandom_range(1, 5), 1);
          drive();
        end
      end
      run_idle(8000);
    end
  endtask
  initial begin
    for (int k = 0; k < N; k++) rq[k].delete();
    test_reset();
    test_contention();
    test_single();
    test_burst();
    test_withdraw();
    test_busy_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
